alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Registered, parametrised successor to the combinational ALU decoder in the EX stage of the RISC-V pipeline. It decodes a widened `ALU_sel` into the existing ALU control fields and registers them with one-cycle latency. It also executes M-extension multiply and divide ops iteratively, stalling the pipeline through a ready/busy handshake. It sits between the ID/EX register and the ALU datapath, and its `md_result` feeds the EX result mux.

## Interface

Parameters:
- `XLEN`, 32, operand and result width; even, ≥ 8
- `SEL_W`, 5, width of `ALU_sel`; ≥ 5

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous abort of the current op
- `in_valid`  in  1  op presented on `ALU_sel`/`op_a`/`op_b`
- `in_ready`  out  1  block accepts an op this cycle
- `ALU_sel`  in  SEL_W  op code
- `op_a`, `op_b`  in  XLEN  rs1/rs2 operands; used only by M ops
- `out_valid`  out  1  registered controls (and `md_result` for M ops) valid this cycle
- `subsel`  out  1  adder subtract select
- `shiftSel`  out  2  00 none, 01 SLL, 10 SRL, 11 SRA
- `logicSel`  out  2  00 none, 01 AND, 10 OR, 11 XOR
- `ALUop_sel`  out  3  000 add/sub, 001 logic, 010 shift, 011 LUI, 100 M-unit result
- `md_result`  out  XLEN  multiply/divide result
- `busy`  out  1  iterative op in progress

## Operation

- Op codes 0–14 are unchanged: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, LUI, BEQ, BNE, BLT, BGE, JAL, JALR.
- Field values for codes 0–14 are unchanged, with `ALUop_sel` zero-extended.
- Codes 15 and above 21 decode to the default: `subsel=1`, all other fields 0.
- M ops: 16 MUL (low XLEN), 17 MULHU (high XLEN, unsigned), 18 DIV, 19 DIVU, 20 REM, 21 REMU. Each decodes to `ALUop_sel=100`, with all other fields 0.
- The FSM has three states: IDLE, CALC and DONE.
  - IDLE: `in_ready=1`. On `in_valid`, a non-M op registers its controls and asserts `out_valid` the next cycle, then stays in IDLE. An M op latches its operands and moves to CALC.
  - CALC: `busy=1`, `in_ready=0`. Runs one shift-add (multiply) or restoring-subtract (divide) step per cycle. A counter runs 0..XLEN-1, and the FSM moves to DONE after step XLEN-1.
  - DONE: applies sign fix-up, asserts `out_valid` with `md_result`, drives `in_ready=0`, then returns to IDLE.
- Signed DIV/REM:
  - Operands are converted to magnitudes on accept.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
- Divide by zero:
  - Quotient = all ones.
  - Remainder = `op_a`.
  - CALC is skipped; the FSM goes IDLE→DONE.
- Signed overflow (−2^(XLEN−1) / −1):
  - Quotient = −2^(XLEN−1).
  - Remainder = 0.
  - CALC is skipped.
- Product accumulates in a 2·XLEN register. MUL returns the low half; MULHU returns the high half. All arithmetic is modulo its width.
- `flush` in any state:
  - The next state is IDLE.
  - `out_valid` is 0 next cycle.
  - Any accepted op is discarded.
  - `flush` wins over a simultaneous `in_valid`; that op is dropped.

## Timing

- Reset values: `out_valid=0`, `subsel=0`, `shiftSel=0`, `logicSel=0`, `ALUop_sel=0`, `md_result=0`, `busy=0`, state IDLE, counter 0. `in_ready=1` while in reset.
- Non-M op: latency 1. Back-to-back accepts are allowed every cycle.
- M op: `out_valid` is asserted XLEN+1 cycles after the accept edge.
- Divide-by-zero and overflow: `out_valid` is asserted 1 cycle after accept.
- `out_valid` is a one-cycle pulse. There is no output backpressure; the pipeline holds via `in_ready`.
- Controls and `md_result` hold their last value when `out_valid=0`.
- Asserting `rst` mid-CALC immediately returns all outputs to their reset values.

## Configuration

- `ALU_MD_EN` defined: M ops are supported as above.
- `ALU_MD_EN` undefined:
  - Codes 16–21 decode to the default.
  - Every op has latency 1.
  - `busy` is tied 0 and `in_ready` is tied 1.
  - `md_result` is tied 0.
  - No CALC/DONE logic or counter is synthesised.

## Structure

- Package `alu_pkg` holds:
  - op-code localparams (0–21)
  - `ALUop_sel`, `shiftSel` and `logicSel` encodings
  - FSM state encoding
- One sub-module, `alu_muldiv_iter`:
  - operand/accumulator registers, iteration counter and step logic
  - sign fix-up and special-case detection
  - compiled only under `ALU_MD_EN`
- The top level holds the decode, the control registers and the FSM.

## Test plan

- Reset, then ADD, SUB, AND, XOR, SRA, LUI and op 15 on consecutive cycles → each result appears 1 cycle later. Expected fields:
  - SUB: `subsel=1`
  - XOR: `logicSel=11`, `ALUop_sel=001`
  - SRA: `shiftSel=11`, `ALUop_sel=010`
  - op 15: default fields
- MUL 0xFFFFFFFF × 2 (XLEN=32) → `busy` high for 32 cycles; `out_valid` at accept+33 with `md_result=0xFFFFFFFE`. MULHU of the same operands → `md_result=0x00000001`.
- DIV −7/2 → `md_result=0xFFFFFFFD`. REM −7/2 → `md_result=0xFFFFFFFF`.
- DIVU 5/0 → `md_result=0xFFFFFFFF` at accept+1. REM 0x80000000/−1 → `md_result=0`.
- MUL accepted, `flush` at iteration 10 → `out_valid` never pulses. The ADD presented with the flush is dropped. The next ADD, on the cycle after the flush, is accepted with latency 1.
- `rst` pulsed mid-CALC → all outputs return to reset values within the reset cycle. With `ALU_MD_EN` undefined, op 16 → default fields at latency 1 and `busy=0`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, control-field encodings, FSM states and the base decoder
// for the registered EX-stage ALU control sequencer.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_LUI   = 5'd8;
    localparam logic [4:0] OP_BEQ   = 5'd9;
    localparam logic [4:0] OP_BNE   = 5'd10;
    localparam logic [4:0] OP_BLT   = 5'd11;
    localparam logic [4:0] OP_BGE   = 5'd12;
    localparam logic [4:0] OP_JAL   = 5'd13;
    localparam logic [4:0] OP_JALR  = 5'd14;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_REM   = 5'd20;
    localparam logic [4:0] OP_REMU  = 5'd21;

    typedef enum logic [2:0] {
        AOP_ADDSUB = 3'b000,
        AOP_LOGIC  = 3'b001,
        AOP_SHIFT  = 3'b010,
        AOP_LUI    = 3'b011,
        AOP_MD     = 3'b100
    } aluop_e;

    typedef enum logic [1:0] {SH_NONE = 2'b00, SH_SLL = 2'b01, SH_SRL = 2'b10, SH_SRA = 2'b11} shift_e;
    typedef enum logic [1:0] {LG_NONE = 2'b00, LG_AND = 2'b01, LG_OR = 2'b10, LG_XOR = 2'b11} logic_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_CALC = 2'b01, ST_DONE = 2'b10} state_e;

    // Low three bits of op codes 16..21 map straight onto this encoding.
    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULHU = 3'd1, MD_DIV = 3'd2,
        MD_DIVU = 3'd3, MD_REM = 3'd4, MD_REMU = 3'd5
    } md_op_e;

    typedef struct packed {
        logic   subsel;
        shift_e shift_sel;
        logic_e logic_sel;
        aluop_e aluop_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO    = '{subsel: 1'b0, shift_sel: SH_NONE, logic_sel: LG_NONE, aluop_sel: AOP_ADDSUB};
    localparam ctrl_t CTRL_DEFAULT = '{subsel: 1'b1, shift_sel: SH_NONE, logic_sel: LG_NONE, aluop_sel: AOP_ADDSUB};
    localparam ctrl_t CTRL_MD      = '{subsel: 1'b0, shift_sel: SH_NONE, logic_sel: LG_NONE, aluop_sel: AOP_MD};

    function automatic ctrl_t decode_base(input logic [4:0] code);
        ctrl_t c;
        c = CTRL_ZERO;
        case (code)
            OP_ADD, OP_JAL, OP_JALR: c = CTRL_ZERO;
            OP_SUB, OP_BEQ, OP_BNE, OP_BLT, OP_BGE: c.subsel = 1'b1;
            OP_AND: begin c.logic_sel = LG_AND; c.aluop_sel = AOP_LOGIC; end
            OP_OR:  begin c.logic_sel = LG_OR;  c.aluop_sel = AOP_LOGIC; end
            OP_XOR: begin c.logic_sel = LG_XOR; c.aluop_sel = AOP_LOGIC; end
            OP_SLL: begin c.shift_sel = SH_SLL; c.aluop_sel = AOP_SHIFT; end
            OP_SRL: begin c.shift_sel = SH_SRL; c.aluop_sel = AOP_SHIFT; end
            OP_SRA: begin c.shift_sel = SH_SRA; c.aluop_sel = AOP_SHIFT; end
            OP_LUI: c.aluop_sel = AOP_LUI;
            default: c = CTRL_DEFAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle, with divide-by-zero / signed-overflow short cuts and sign fix-up.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  md_op_e          op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg, spec_res_reg, spec_res, abs_a, abs_b, quo, rem, fixed;
    logic [CNT_W-1:0]  cnt_reg;
    md_op_e            op_reg;
    logic              neg_q_reg, neg_r_reg, special_reg;
    logic              is_mul, is_signed, is_quot, div_zero, overflow, mul_active;
    logic [XLEN:0]     mul_sum, rem_sh, diff;

    assign is_mul    = (op == MD_MUL) || (op == MD_MULHU);
    assign is_signed = (op == MD_DIV) || (op == MD_REM);
    assign is_quot   = (op == MD_DIV) || (op == MD_DIVU);
    assign div_zero  = !is_mul && (op_b == '0);
    assign overflow  = is_signed && (op_a == MIN_NEG) && (op_b == '1);
    assign special   = div_zero || overflow;
    assign spec_res  = div_zero ? (is_quot ? '1 : op_a) : (is_quot ? MIN_NEG : '0);
    assign abs_a     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign abs_b     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;

    // acc_reg is {product high, multiplier} for multiply, {remainder, quotient} for divide.
    assign mul_active = (op_reg == MD_MUL) || (op_reg == MD_MULHU);
    assign mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign rem_sh     = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign diff       = rem_sh - {1'b0, opnd_reg};

    always_comb begin
        acc_next = acc_reg;
        if (mul_active)
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
        else if (diff[XLEN])
            acc_next = {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        else
            acc_next = {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end

    assign quo = acc_reg[XLEN-1:0];
    assign rem = acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        fixed = '0;
        case (op_reg)
            MD_MUL, MD_DIVU:   fixed = quo;
            MD_MULHU, MD_REMU: fixed = rem;
            MD_DIV:            fixed = neg_q_reg ? -quo : quo;
            MD_REM:            fixed = neg_r_reg ? -rem : rem;
            default:           fixed = '0;
        endcase
    end

    assign result = special_reg ? spec_res_reg : fixed;
    assign last   = (cnt_reg == CNT_W'(XLEN-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            opnd_reg     <= '0;
            cnt_reg      <= '0;
            op_reg       <= MD_MUL;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            special_reg  <= 1'b0;
            spec_res_reg <= '0;
        end else if (start) begin
            op_reg       <= op;
            acc_reg      <= {{XLEN{1'b0}}, (is_mul ? op_b : abs_a)};
            opnd_reg     <= is_mul ? op_a : abs_b;
            cnt_reg      <= '0;
            neg_q_reg    <= is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_r_reg    <= is_signed && op_a[XLEN-1];
            special_reg  <= special;
            spec_res_reg <= spec_res;
        end else if (step) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with optional iterative M-extension unit.
// Define ALU_MD_EN to build the multiply/divide path; otherwise codes 16-21 decode as default.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] ALU_sel,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             out_valid,
    output logic             subsel,
    output logic [1:0]       shiftSel,
    output logic [1:0]       logicSel,
    output logic [2:0]       ALUop_sel,
    output logic [XLEN-1:0]  md_result,
    output logic             busy
);
    ctrl_t dec_ctrl, ctrl_reg;
    logic  out_valid_reg, sel_low, is_m_op, accept, md_done;

    // Codes wider than five bits are always outside the defined op space.
    assign sel_low  = ((ALU_sel >> 5) == '0);
    assign dec_ctrl = sel_low ? decode_base(ALU_sel[4:0]) : CTRL_DEFAULT;

`ifdef ALU_MD_EN
    state_e          state_reg, state_next;
    logic            md_start, md_step, md_special, md_last;
    logic [XLEN-1:0] md_res, md_result_reg;

    assign is_m_op = sel_low && (ALU_sel[4:0] >= OP_MUL) && (ALU_sel[4:0] <= OP_REMU);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (md_start),
        .step    (md_step),
        .op      (md_op_e'(ALU_sel[2:0])),
        .op_a    (op_a),
        .op_b    (op_b),
        .special (md_special),
        .last    (md_last),
        .result  (md_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        md_start   = 1'b0;
        md_step    = 1'b0;
        md_done    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid && !flush;
                if (accept && is_m_op) begin
                    md_start   = 1'b1;
                    state_next = md_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy    = 1'b1;
                md_step = !flush;
                if (md_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                md_done    = !flush;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          md_result_reg <= '0;
        else if (md_done) md_result_reg <= md_res;
    end

    assign md_result = md_result_reg;
`else
    logic unused_md_ops;

    assign unused_md_ops = ^{op_a, op_b};
    assign is_m_op   = 1'b0;
    assign md_done   = 1'b0;
    assign accept    = in_valid && !flush;
    assign in_ready  = 1'b1;
    assign busy      = 1'b0;
    assign md_result = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg      <= CTRL_ZERO;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept && !is_m_op) begin
                ctrl_reg      <= dec_ctrl;
                out_valid_reg <= 1'b1;
            end else if (md_done) begin
                ctrl_reg      <= CTRL_MD;
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign subsel    = ctrl_reg.subsel;
    assign shiftSel  = ctrl_reg.shift_sel;
    assign logicSel  = ctrl_reg.logic_sel;
    assign ALUop_sel = ctrl_reg.aluop_sel;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomised self-checking bench for alu_ctrl_seq against an arithmetic reference model;
// adapts to whether ALU_MD_EN is defined.
module tb_alu_ctrl_seq;

`ifdef ALU_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk, rst, flush, in_valid, in_ready, out_valid, subsel, busy;
    logic [4:0]  ALU_sel;
    logic [31:0] op_a, op_b, md_result;
    logic [1:0]  shiftSel, logicSel;
    logic [2:0]  ALUop_sel;

    alu_ctrl_seq #(.XLEN(32), .SEL_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_sel   (ALU_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .subsel    (subsel),
        .shiftSel  (shiftSel),
        .logicSel  (logicSel),
        .ALUop_sel (ALUop_sel),
        .md_result (md_result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  ctrl;
        logic [31:0] md;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mdl_md = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {subsel, shiftSel, logicSel, ALUop_sel} from the op table.
    function automatic logic [7:0] ctrl_ref(input logic [4:0] sel);
        case (sel)
            5'd0, 5'd13, 5'd14:        return 8'b0_00_00_000;
            5'd1, 5'd9, 5'd10, 5'd11, 5'd12: return 8'b1_00_00_000;
            5'd2:  return 8'b0_00_01_001;
            5'd3:  return 8'b0_00_10_001;
            5'd4:  return 8'b0_00_11_001;
            5'd5:  return 8'b0_01_00_010;
            5'd6:  return 8'b0_10_00_010;
            5'd7:  return 8'b0_11_00_010;
            5'd8:  return 8'b0_00_00_011;
            default: return (MD_EN && sel >= 5'd16 && sel <= 5'd21) ? 8'b0_00_00_100 : 8'b1_00_00_000;
        endcase
    endfunction

    function automatic bit is_ovf(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        return (sel == 5'd18 || sel == 5'd20) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic bit is_special(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        return (sel >= 5'd18 && sel <= 5'd21 && b == 32'd0) || is_ovf(sel, a, b);
    endfunction

    function automatic logic [31:0] md_ref(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        p = {32'd0, a} * {32'd0, b};
        r = '0;
        case (sel)
            5'd16: r = p[31:0];
            5'd17: r = p[63:32];
            5'd18: r = (b == 0) ? 32'hFFFF_FFFF : is_ovf(sel, a, b) ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            5'd19: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd20: r = (b == 0) ? a : is_ovf(sel, a, b) ? 32'd0 : 32'($signed(a) % $signed(b));
            5'd21: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Every cycle out of reset: out_valid must match the scoreboard's due time.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid || (exp_q.size() != 0 && exp_q[0].due <= cyc))
                check("out_valid", out_valid, (exp_q.size() != 0 && exp_q[0].due == cyc));
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                if (out_valid) begin
                    check("ctrl", {subsel, shiftSel, logicSel, ALUop_sel}, mon_e.ctrl);
                    check("md_result", md_result, mon_e.md);
                end
            end
        end
    end

    task automatic send(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   m_op, spc;
        int   wait_n;
        m_op = MD_EN && sel >= 5'd16 && sel <= 5'd21;
        spc  = m_op && is_special(sel, a, b);
        check("in_ready_idle", in_ready, 1);
        ALU_sel  = sel;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        if (m_op) mdl_md = md_ref(sel, a, b);
        e.due  = cyc + (!m_op ? 1 : (spc ? 2 : 34));
        e.ctrl = ctrl_ref(sel);
        e.md   = mdl_md;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (m_op) begin
            wait_n = spc ? 1 : 33;
            for (int k = 1; k <= wait_n; k++) begin
                check("busy", busy, (!spc && k <= 32));
                check("in_ready_busy", in_ready, 0);
                @(negedge clk);
            end
        end
    endtask

    task automatic start_raw(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        ALU_sel  = sel;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_subsel"}, subsel, 0);
        check({tag, "_shiftSel"}, shiftSel, 0);
        check({tag, "_logicSel"}, logicSel, 0);
        check({tag, "_ALUop_sel"}, ALUop_sel, 0);
        check({tag, "_md_result"}, md_result, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    logic [4:0]  r_sel;
    logic [31:0] r_a, r_b;
    int          r_mode;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        ALU_sel = '0; op_a = '0; op_b = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back single-cycle ops
        send(5'd0, 32'd1, 32'd2);
        send(5'd1, 32'd1, 32'd2);
        send(5'd2, 32'd1, 32'd2);
        send(5'd4, 32'd1, 32'd2);
        send(5'd7, 32'd1, 32'd2);
        send(5'd8, 32'd1, 32'd2);
        send(5'd15, 32'd1, 32'd2);

        // Multiply / divide directed cases
        send(5'd16, 32'hFFFF_FFFF, 32'd2);
        send(5'd17, 32'hFFFF_FFFF, 32'd2);
        send(5'd18, 32'hFFFF_FFF9, 32'd2);
        send(5'd20, 32'hFFFF_FFF9, 32'd2);
        send(5'd19, 32'd5, 32'd0);
        send(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        send(5'd3, 32'd0, 32'd0);

        // Flush in idle drops the op presented with it
        flush = 1'b1; in_valid = 1'b1; ALU_sel = 5'd0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

`ifdef ALU_MD_EN
        // Flush at iteration 10 of a multiply
        start_raw(5'd16, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int k = 0; k < 10; k++) begin
            check("busy_pre_flush", busy, 1);
            @(negedge clk);
        end
        flush = 1'b1; in_valid = 1'b1; ALU_sel = 5'd0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("busy_post_flush", busy, 0);
`endif
        send(5'd0, 32'd0, 32'd0);
        repeat (40) @(negedge clk);

        // Reset asserted mid-operation
`ifdef ALU_MD_EN
        start_raw(5'd18, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        check("busy_pre_reset", busy, 1);
`else
        send(5'd4, 32'd0, 32'd0);
`endif
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        mdl_md = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(5'd16, 32'd3, 32'd4);
        send(5'd5, 32'd0, 32'd0);

        // Randomised traffic with biased special cases
        for (int i = 0; i < 60; i++) begin
            r_sel  = 5'($urandom_range(0, 31));
            if (i % 3 == 0) r_sel = 5'($urandom_range(16, 21));
            r_a    = $urandom;
            r_b    = $urandom;
            r_mode = $urandom_range(0, 7);
            if (r_mode == 0) r_b = 32'd0;
            else if (r_mode == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
            else if (r_mode == 2) r_b = 32'($urandom_range(1, 9));
            send(r_sel, r_a, r_b);
        end

        repeat (40) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
